// File: rtl/rng_health_fifo.sv
// Health-tested FIFO for the 32-bit random word stream: repetition-count and
// adaptive-proportion tests gate words into a first-word-fall-through FIFO.
module rng_health_fifo #(
    parameter int DEPTH     = 4,
    parameter int WIN_WORDS = 16,
    parameter int ONES_LO   = 192,
    parameter int ONES_HI   = 320,
    parameter int REP_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    input  logic                      rd_en,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      healthy,
    output logic                      fail,
    output logic [1:0]                fail_code,
    output logic                      overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int ACC_W  = $clog2(WIN_WORDS * 32) + 1;
    localparam int WCNT_W = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;

    localparam logic [LVL_W-1:0]  DEPTH_V   = LVL_W'(DEPTH);
    localparam logic [ACC_W-1:0]  LO_V      = ACC_W'(ONES_LO);
    localparam logic [ACC_W-1:0]  HI_V      = ACC_W'(ONES_HI);
    localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WIN_WORDS - 1);
    localparam logic [REP_W-1:0]  REP_LIM_V = REP_W'(REP_LIMIT);

    function automatic logic [5:0] popcount(input logic [31:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, w[i]};
        end
        return c;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [31:0]       prev_q, prev_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [REP_W-1:0]  rep_new;
    logic [ACC_W-1:0]  total;
    logic              win_end;
    logic              rep_fail;
    logic              prop_fail;
    logic              pop;
    logic              push;
    logic              full;

    always_comb begin
        rep_new = '0;
        if (rep_cnt_q != '0 && in_data == prev_q) begin
            rep_new = (rep_cnt_q == REP_LIM_V) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
        end else begin
            rep_new = REP_W'(1);
        end
        rep_fail  = (rep_new >= REP_LIM_V);
        win_end   = (wcnt_q == WIN_LAST);
        total     = acc_q + ACC_W'(popcount(in_data));
        prop_fail = win_end && ((total < LO_V) || (total > HI_V));
        full      = (count_q == DEPTH_V);
        pop       = rd_en && (count_q != '0);
        push      = in_valid && (state_q == ST_RUN) && !rep_fail && !prop_fail;
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        fail_code_d = fail_code_q;
        prev_d      = prev_q;
        rep_cnt_d   = rep_cnt_q;
        acc_d       = acc_q;
        wcnt_d      = wcnt_q;

        if (state_q != ST_FAIL) begin
            if (!en) begin
                // Soft flush: drop everything and re-qualify the source from scratch.
                state_d    = ST_STARTUP;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
                rep_cnt_d  = '0;
                acc_d      = '0;
                wcnt_d     = '0;
            end else if (in_valid && (rep_fail || prop_fail)) begin
                state_d     = ST_FAIL;
                fail_code_d = {prop_fail, rep_fail};
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                count_d     = '0;
            end else begin
                if (in_valid) begin
                    prev_d    = in_data;
                    rep_cnt_d = rep_new;
                    acc_d     = win_end ? '0 : total;
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                    if (state_q == ST_STARTUP && win_end) begin
                        state_d   = ST_RUN;
                        rep_cnt_d = '0;
                    end
                end
                // A pop frees the head slot this edge, so a push into a full FIFO still lands.
                if (push && (!full || pop)) begin
                    mem_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                end
                if (push && full && !pop) begin
                    overflow_d = 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (push && !full && !pop) begin
                    count_d = count_q + LVL_W'(1);
                end else if (pop && !push) begin
                    count_d = count_q - LVL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_STARTUP;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            fail_code_q <= 2'b00;
            prev_q      <= '0;
            rep_cnt_q   <= '0;
            acc_q       <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            fail_code_q <= fail_code_d;
            prev_q      <= prev_d;
            rep_cnt_q   <= rep_cnt_d;
            acc_q       <= acc_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign level     = count_q;
    assign healthy   = (state_q == ST_RUN);
    assign fail      = (state_q == ST_FAIL);
    assign fail_code = fail_code_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/rng_health_fifo.md
# rng_health_fifo

Downstream consumer of the 32-bit random word generator. It accepts each fresh word (one-cycle `in_valid` pulse) and runs two online health tests on the word stream: a repetition-count test and an adaptive-proportion test. Words that pass go into a small first-word-fall-through FIFO, which the system-side reader drains with a pop strobe. Any health failure latches a sticky alarm and flushes the FIFO, so no word from a suspect source is ever delivered.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `WIN_WORDS`, 16: proportion-test window in words; power of 2.
- `ONES_LO`, 192: minimum ones per window (inclusive).
- `ONES_HI`, 320: maximum ones per window (inclusive).
- `REP_LIMIT`, 3: consecutive identical words that constitute a failure; ≥2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  enable; low = soft flush (see Operation).
- `in_data`  in  32  word from generator.
- `in_valid`  in  1  one-cycle strobe, `in_data` valid.
- `rd_en`  in  1  pop head word; ignored when `out_valid`=0.
- `out_data`  out  32  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.
- `healthy`  out  1  state==RUN.
- `fail`  out  1  sticky health alarm.
- `fail_code`  out  2  bit0 = repetition, bit1 = proportion; sticky.
- `overflow`  out  1  sticky: a passing word was dropped because FIFO was full.

## Operation
- States: STARTUP, RUN, FAIL.
- STARTUP: the first WIN_WORDS accepted words are tested and never pushed. If the window completes with no failure, go to RUN. The window counter and ones accumulator restart at 0.
- RUN: every word is tested. A passing word is pushed.
- FAIL: `fail`=1 and `fail_code` holds its value. The FIFO is flushed (level 0), `in_valid` and `rd_en` are ignored. Only `rst_n`=0 exits FAIL.
- Repetition test:
  - Hold `prev_word` and `rep_cnt`. On the first word after reset, flush, or leaving STARTUP, set `rep_cnt`=1.
  - If `in_data`==`prev_word`, `rep_cnt`+1; otherwise `rep_cnt`=1.
  - Fail when the new `rep_cnt` reaches REP_LIMIT. `rep_cnt` saturates, with no wrap.
- Proportion test:
  - `acc` += popcount(`in_data`). `acc` width is clog2(WIN_WORDS*32)+1 (10 bits at defaults), so it cannot overflow.
  - On the WIN_WORDSth word of a window, evaluate total = `acc` + popcount. Fail if total < ONES_LO or total > ONES_HI.
  - `acc` and the word counter then clear. The counter wraps modulo WIN_WORDS.
- Both tests failing on the same word: `fail_code`=2'b11. A failing word is never pushed.
- FIFO:
  - Push when full and no pop: word dropped, `overflow`=1.
  - Push and pop in the same cycle: allowed at any level, including full. Level is unchanged, and the pushed word is not dropped.
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH.
- `en`=0 in STARTUP/RUN:
  - Flush the FIFO; clear `overflow`, `acc`, window counter and `rep_cnt`.
  - Go to STARTUP and stay there while `en`=0. Inputs are ignored.
- `en`=0 in FAIL: no effect.
- `rst_n`=0: all state and outputs return to reset values regardless of state or `en`.

## Timing
- Reset values:
  - `out_data`=0 (storage cleared); `out_valid`=0, `level`=0.
  - `healthy`=0, `fail`=0, `fail_code`=0, `overflow`=0; state STARTUP.
- A word strobed at edge N appears at `out_data` with `out_valid`=1 after edge N (1-cycle latency) when the FIFO was empty. `level` updates on the same edge.
- A failing word at edge N sets `fail`/`fail_code` and `out_valid`=0, `level`=0 after edge N.
- STARTUP→RUN: `healthy`=1 after the edge that accepts the WIN_WORDSth passing word.
- `rd_en` at edge N with `out_valid`=1: the next entry (or `out_valid`=0) is presented after edge N.
- `out_data` and `out_valid` are driven from registers/storage only, with no combinational path from inputs.

## Test plan
- Startup pass: 16 words alternating 0xA5A5A5A5/0x5A5A5A5A (total 256 ones) -> `out_valid`=0 throughout, `healthy`=1 after the 16th. Then 0x0F0F0F0F -> `out_data`=0x0F0F0F0F, `level`=1 next cycle.
- Repetition: in RUN, send 0x00FFFF00 three times consecutively -> after the third, `fail`=1, `fail_code`=01, `level`=0, `healthy`=0. Further `in_valid` and `rd_en` have no effect.
- Proportion: in STARTUP, 16 words alternating 0xFFFFFFFF/0xFFFFFFFE (total 504) -> `fail_code`=10 after the 16th. Repeat after reset with 0x00000001/0x00000003 (24) -> `fail_code`=10.
- FIFO full: in RUN, push 0x0000FFFF, 0xFFFF0000, 0x00FFFF00, 0xFF0000FF, then 0x0F0F0F0F with no pops -> `level`=4, `overflow`=1, `out_data`=0x0000FFFF.
  - Pop 4 times -> the four words in order, then `out_valid`=0.
- Simultaneous: full FIFO, `rd_en` and `in_valid` with 0xF0F0F0F0 on the same edge -> `level` stays 4, `overflow` unchanged, 0xF0F0F0F0 read out last.
- Soft flush/reset: RUN with `level`=2, drop `en` -> `level`=0, `healthy`=0, `overflow`=0, state STARTUP. In FAIL, `en` toggling keeps `fail`=1. `rst_n`=0 for one cycle clears `fail`/`fail_code` to 0.
